// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the vector RAM responder
package vram_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam int NBEATS = 4;
  localparam int BEAT_CNT_W = 2;
  localparam int OFFSET_BITS = 5;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/vram_beat_array.sv
// vram_beat_array: word array with one registered read port and one bit-masked write port
module vram_beat_array #(
  parameter int BEAT_W = 64,
  parameter int DEPTH = 4096,
  parameter int IW = 12
) (
  input logic clk,
  input logic we,
  input logic [IW-1:0] waddr,
  input logic [BEAT_W-1:0] wdata,
  input logic [BEAT_W-1:0] wmask,
  input logic re,
  input logic [IW-1:0] raddr,
  output logic [BEAT_W-1:0] q
);
  logic [BEAT_W-1:0] mem [DEPTH];
  // masked write and registered read; the controller never issues both in one cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/vram_responder.sv
// vram_responder: serves 256-bit requests as four 64-bit beats over a beat array
module vram_responder
  import vram_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int BEAT_W = 64,
  parameter int DEPTH = 4096
) (
  input logic clk,
  input logic rst,
  input logic ren,
  input logic [31:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic rvalid,
  input logic wen,
  input logic [31:0] waddr,
  input logic [DATA_W-1:0] wdata,
  input logic [DATA_W-1:0] wmask,
  output logic busy
);
  localparam int IW = idx_w(DEPTH);
  state_t state, nxt;
  logic [BEAT_CNT_W-1:0] cnt;
  logic [IW-3:0] whi, rhi;
  logic [NBEATS-1:0][BEAT_W-1:0] wd, wm;
  logic [NBEATS-2:0][BEAT_W-1:0] stage;
  logic [DATA_W-1:0] rdata_q;
  logic [BEAT_W-1:0] q;
  logic rd_pend, last, unused;
  assign last = cnt == BEAT_CNT_W'(NBEATS - 1);
  assign busy = state != IDLE;
  // the last beat is still in the array output register when rvalid fires, so it bypasses the hold register
  assign rdata = rvalid ? {q, stage} : rdata_q;
  assign unused = ^{raddr[31:IW+3], raddr[OFFSET_BITS-1:0], waddr[31:IW+3], waddr[OFFSET_BITS-1:0]};
  vram_beat_array #(.BEAT_W(BEAT_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk(clk),
    .we(state == WR && !rst),
    .waddr({whi, cnt}),
    .wdata(wd[cnt]),
    .wmask(wm[cnt]),
    .re(state == RD),
    .raddr({rhi, cnt}),
    .q(q)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state: writes run first so a paired read returns the new data
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = wen ? WR : ren ? RD : IDLE;
    else if (last) nxt = state == WR && rd_pend ? RD : IDLE;
  end
  // beat counter, request latches, read staging and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rd_pend <= 1'b0;
      rvalid <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid <= state == RD && last;
      if (rvalid) rdata_q <= {q, stage};
      cnt <= busy ? cnt + 1'b1 : '0;
      if (!busy) begin
        rd_pend <= ren && wen;
        if (wen) begin
          whi <= waddr[IW+2:OFFSET_BITS];
          wd <= wdata;
          wm <= wmask;
        end
        if (ren) rhi <= raddr[IW+2:OFFSET_BITS];
      end
      if (state == RD && cnt != '0) stage[cnt - 1'b1] <= q;
    end
  end
endmodule
